// File: rtl/tiny_io_stim.sv
// tiny_io_stim: Wishbone-programmable clock/reset/data stimulus and output capture for an 8-bit tiny user design.
module tiny_io_stim #(
  parameter int          DIV_W    = 16,
  parameter int          STEP_W   = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  user_in_o,
  input  logic [7:0]  user_out_i,
  output logic        irq_o
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t            state;
  logic [3:0]        ctrl;
  logic [DIV_W-1:0]  div, pc;
  logic [STEP_W-1:0] steps;
  logic [5:0]        data;
  logic [7:0]        capt, sync1, sync2;
  logic              cap_new, cap_ovr, done, uclk;
  logic              hit, acc, wr, rd, go, cap, start, unused_ok;
  logic [5:0]        idx;
  logic [31:0]       wm, wv, rdata;
  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign acc = wbs_ack_o & wbs_cyc_i & wbs_stb_i;
  assign wr = acc & wbs_we_i;
  assign rd = acc & ~wbs_we_i;
  assign idx = wbs_adr_i[7:2];
  assign wm = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wv = wbs_dat_i & wm;
  assign unused_ok = ^{wv, wm, wbs_adr_i[1:0]};
  assign go = ctrl[0] & (ctrl[2] | (steps != '0));
  assign cap = (state == LOW) && (pc == '0);
  assign start = go & ((state == IDLE) | cap);
  // Every bit driven to the user design comes straight from a flop.
  assign user_in_o = {data, ctrl[1], uclk};
  assign wbs_dat_o = wbs_ack_o ? rdata : '0;
  always_comb begin
    rdata = '0;
    case (idx)
      6'h0: rdata[3:0] = ctrl;
      6'h1: rdata[DIV_W-1:0] = div;
      6'h2: rdata[STEP_W-1:0] = steps;
      6'h3: rdata[5:0] = data;
      6'h4: rdata[9:0] = {cap_ovr, cap_new, capt};
      6'h5: rdata[1:0] = {done, state != IDLE};
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      ctrl      <= 4'h2;
      div       <= '0;
      pc        <= '0;
      steps     <= '0;
      data      <= '0;
      capt      <= '0;
      sync1     <= '0;
      sync2     <= '0;
      cap_new   <= 1'b0;
      cap_ovr   <= 1'b0;
      done      <= 1'b0;
      uclk      <= 1'b0;
      wbs_ack_o <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= hit & ~wbs_ack_o;
      sync1 <= user_out_i;
      sync2 <= sync1;
      irq_o <= done & ctrl[3];
      if (wr && idx == 6'h0) ctrl <= (ctrl & ~wm[3:0]) | wv[3:0];
      if (wr && idx == 6'h1) div <= (div & ~wm[DIV_W-1:0]) | wv[DIV_W-1:0];
      if (wr && idx == 6'h3) data <= (data & ~wm[5:0]) | wv[5:0];
      if (wr && idx == 6'h5 && wv[1]) done <= 1'b0;
      if (start) begin
        state <= HIGH;
        uclk  <= 1'b1;
        pc    <= div;
        if (!ctrl[2]) steps <= steps - 1'b1;
      end else if (cap) begin
        state <= IDLE;
        // Only a counted run that exhausted its steps reports completion.
        if (ctrl[0] & ~ctrl[2]) done <= 1'b1;
      end else if (state == HIGH && pc == '0) begin
        state <= LOW;
        uclk  <= 1'b0;
        pc    <= div;
      end else if (state != IDLE) begin
        pc <= pc - 1'b1;
      end
      if (wr && idx == 6'h2) steps <= (steps & ~wm[STEP_W-1:0]) | wv[STEP_W-1:0];
      if (cap) begin
        capt    <= sync2;
        cap_new <= 1'b1;
        cap_ovr <= (rd && idx == 6'h4) ? 1'b0 : (cap_ovr | cap_new);
      end else if (rd && idx == 6'h4) begin
        cap_new <= 1'b0;
        cap_ovr <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tiny_io_stim.sv
// tb_tiny_io_stim: randomized Wishbone-driven checks of tiny_io_stim against a pulse-train/capture model.
module tb_tiny_io_stim;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic        clk = 1'b0, rst_n = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0, rdat;
  logic        ack, irq;
  logic [7:0]  uin, uout = 8'h00;
  int          checks = 0, errors = 0;
  int          hi_q[$], lo_q[$];
  logic        prev = 1'b0;
  int          run = 0;
  always #5 clk = ~clk;
  tiny_io_stim dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .user_in_o(uin), .user_out_i(uout), .irq_o(irq)
  );
  // Records completed high/low run lengths of the generated user clock in wb_clk cycles.
  always @(posedge clk) begin
    if (uin[0] !== prev) begin
      if (prev) hi_q.push_back(run);
      else lo_q.push_back(run);
    end
    run  <= (uin[0] === prev) ? run + 1 : 1;
    prev <= uin[0];
  end
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q, output bit ok);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = 4'hF; ok = 1'b0; q = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1'b1; q = rdat; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] q;
    bit ok;
    wb_xfer(1'b1, BASE + 32'(off), d, q, ok);
  endtask
  task automatic rd(input logic [7:0] off, output logic [31:0] q);
    bit ok;
    wb_xfer(1'b0, BASE + 32'(off), '0, q, ok);
  endtask
  task automatic wait_done(output bit ok);
    logic [31:0] q;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rd(8'h14, q);
      if (q[1]) begin ok = 1'b1; break; end
    end
  endtask
  task automatic run_steps(input int dv, input int n, output bit ok);
    wr(8'h00, 32'h0);
    wr(8'h14, 32'h2);
    wr(8'h04, 32'(dv));
    wr(8'h08, 32'(n));
    hi_q.delete();
    lo_q.delete();
    wr(8'h00, 32'h1);
    wait_done(ok);
    wr(8'h00, 32'h0);
  endtask
  task automatic test_reset;
    logic [31:0] q;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (uin !== 8'h02) begin errors++; $display("FAIL reset_uin got %h exp 02", uin); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    @(negedge clk); rst_n = 1'b1;
    rd(8'h00, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL reset_ctrl got %h exp 2", q); end
    rd(8'h14, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_stat got %h exp 0", q); end
    rd(8'h04, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_div got %h exp 0", q); end
    rd(8'h10, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_capt got %h exp 0", q); end
  endtask
  task automatic test_steps;
    logic [31:0] q;
    bit ok;
    run_steps(2, 3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL steps_done got 0 exp 1"); end
    checks++; if (hi_q.size() !== 3) begin errors++; $display("FAIL steps_pulses got %0d exp 3", hi_q.size()); end
    foreach (hi_q[i]) begin
      checks++; if (hi_q[i] !== 3) begin errors++; $display("FAIL steps_high[%0d] got %0d exp 3", i, hi_q[i]); end
    end
    for (int i = 1; i < lo_q.size(); i++) begin
      checks++; if (lo_q[i] !== 3) begin errors++; $display("FAIL steps_low[%0d] got %0d exp 3", i, lo_q[i]); end
    end
    rd(8'h08, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL steps_remaining got %h exp 0", q); end
    rd(8'h14, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL steps_stat got %h exp 2", q); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL steps_irq_masked got %b exp 0", irq); end
  endtask
  task automatic test_capture;
    logic [31:0] q;
    bit ok;
    uout = 8'hA5;
    repeat (3) @(posedge clk);
    rd(8'h10, q);
    run_steps(0, 1, ok);
    rd(8'h10, q);
    checks++; if (q !== 32'h1A5) begin errors++; $display("FAIL capt_new got %h exp 1a5", q); end
    rd(8'h10, q);
    checks++; if (q !== 32'h0A5) begin errors++; $display("FAIL capt_reread got %h exp 0a5", q); end
    uout = 8'h3C;
    repeat (3) @(posedge clk);
    run_steps(1, 2, ok);
    rd(8'h10, q);
    checks++; if (q !== 32'h33C) begin errors++; $display("FAIL capt_ovr got %h exp 33c", q); end
  endtask
  task automatic test_random;
    logic [31:0] q;
    bit ok;
    int dv, n, bad;
    logic [7:0] v;
    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(0, 4);
      n  = $urandom_range(1, 4);
      v  = 8'($urandom);
      uout = v;
      repeat (3) @(posedge clk);
      rd(8'h10, q);
      run_steps(dv, n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_done it%0d got 0 exp 1", it); end
      checks++; if (hi_q.size() !== n) begin errors++; $display("FAIL rand_pulses it%0d got %0d exp %0d", it, hi_q.size(), n); end
      bad = 0;
      foreach (hi_q[i]) if (hi_q[i] != dv + 1) bad++;
      for (int i = 1; i < lo_q.size(); i++) if (lo_q[i] != dv + 1) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand_widths it%0d got %0d bad exp 0 (div %0d)", it, bad, dv); end
      rd(8'h10, q);
      checks++; if (q !== {22'h0, n > 1, 1'b1, v}) begin errors++; $display("FAIL rand_capt it%0d got %h exp %h", it, q, {22'h0, n > 1, 1'b1, v}); end
      rd(8'h08, q);
      checks++; if (q !== 32'h0) begin errors++; $display("FAIL rand_remaining it%0d got %h exp 0", it, q); end
    end
  endtask
  task automatic test_free_stop;
    logic [31:0] q;
    bit seen;
    int bad;
    wr(8'h00, 32'h0);
    wr(8'h14, 32'h2);
    wr(8'h04, 32'h7);
    hi_q.delete();
    lo_q.delete();
    wr(8'h00, 32'h5);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (uin[0]) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL free_start got 0 exp 1"); end
    wr(8'h00, 32'h4);
    for (int i = 0; i < 100; i++) begin
      rd(8'h14, q);
      if (!q[0]) break;
    end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL free_stat got %h exp 0", q); end
    checks++; if (hi_q.size() < 1) begin errors++; $display("FAIL free_pulses got %0d exp >=1", hi_q.size()); end
    bad = 0;
    foreach (hi_q[i]) if (hi_q[i] != 8) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL free_width got %0d bad exp 0", bad); end
    checks++; if (uin[0] !== 1'b0) begin errors++; $display("FAIL free_uclk got %b exp 0", uin[0]); end
    rd(8'h08, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL free_steps got %h exp 0", q); end
    wr(8'h00, 32'h0);
  endtask
  task automatic test_irq;
    logic [31:0] q;
    bit ok;
    wr(8'h14, 32'h2);
    wr(8'h04, 32'h0);
    wr(8'h08, 32'h1);
    wr(8'h00, 32'h9);
    wait_done(ok);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    wr(8'h14, 32'h2);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
    rd(8'h14, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL irq_stat got %h exp 0", q); end
    wr(8'h00, 32'h0);
  endtask
  task automatic test_data;
    logic [31:0] q;
    logic [5:0] d;
    d = 6'($urandom);
    wr(8'h0C, {26'h3FFFFFF, d});
    @(posedge clk); #1;
    checks++; if (uin !== {d, 2'b00}) begin errors++; $display("FAIL data_uin got %h exp %h", uin, {d, 2'b00}); end
    rd(8'h0C, q);
    checks++; if (q !== {26'h0, d}) begin errors++; $display("FAIL data_read got %h exp %h", q, {26'h0, d}); end
  endtask
  task automatic test_decode;
    logic [31:0] q;
    bit ok;
    wr(8'h04, 32'h5);
    wb_xfer(1'b0, BASE + 32'h40, '0, q, ok);
    checks++; if (!ok || q !== 32'h0) begin errors++; $display("FAIL dec_unmapped got ack %b data %h exp ack 1 data 0", ok, q); end
    wb_xfer(1'b1, BASE + 32'h44, 32'hFFFF_FFFF, q, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dec_unmapped_wr got ack 0 exp 1"); end
    rd(8'h04, q);
    checks++; if (q !== 32'h5) begin errors++; $display("FAIL dec_div_kept got %h exp 5", q); end
    wb_xfer(1'b0, BASE + 32'h100, '0, q, ok);
    checks++; if (ok) begin errors++; $display("FAIL dec_miss_rd got ack 1 exp 0"); end
    wb_xfer(1'b1, BASE + 32'h104, 32'h9, q, ok);
    checks++; if (ok) begin errors++; $display("FAIL dec_miss_wr got ack 1 exp 0"); end
    rd(8'h04, q);
    checks++; if (q !== 32'h5) begin errors++; $display("FAIL dec_miss_kept got %h exp 5", q); end
  endtask
  task automatic test_reset_midrun;
    logic [31:0] q;
    bit seen;
    wr(8'h04, 32'h5);
    wr(8'h00, 32'h5);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (uin[0]) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_run_start got 0 exp 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (uin !== 8'h02) begin errors++; $display("FAIL rst_async_uin got %h exp 02", uin); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_async_ack got %b exp 0", ack); end
    @(negedge clk); rst_n = 1'b1;
    rd(8'h14, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_stat got %h exp 0", q); end
    rd(8'h00, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL rst_ctrl got %h exp 2", q); end
    rd(8'h04, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_div got %h exp 0", q); end
  endtask
  initial begin
    test_reset();
    test_steps();
    test_capture();
    test_random();
    test_free_stop();
    test_irq();
    test_data();
    test_decode();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
